music_sequencer: RTL
====================

# music_sequencer

Parametrised multi-song beat sequencer for the audio path: up to NUM_SONGS independent songs, each with its own tempo counter, length and loop mode. It replaces fixed clock dividers and a hard-wired song set. A fixed priority picks one playing song, converts its tone ROM frequencies to note divisors with an iterative divider, and drives `note_gen`. It sits between game-control logic (song triggers) and `note_gen`/`speaker_control`.

## Interface
- NUM_SONGS, 9, number of song slots (1..16)
- BEAT_W, 12, beat counter width
- TEMPO_W, 24, tempo count width (clk cycles per beat)
- FREQ_W, 32, tone ROM frequency width (Hz)
- NDIV_W, 22, note divisor output width
- DIV_NUM, 50_000_000, dividend: note_div = DIV_NUM / tone

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- trigger  in  NUM_SONGS  per-song start/restart, level-sampled each cycle
- stop  in  1  abort all songs
- loop_en  in  NUM_SONGS  per-song loop mode
- tempo_div  in  NUM_SONGS*TEMPO_W  per-song cycles per beat, slot i at [i*TEMPO_W +: TEMPO_W]
- song_len  in  NUM_SONGS*BEAT_W  per-song length in beats
- tone_l, tone_r  in  NUM_SONGS*FREQ_W  per-song tone ROM outputs for the current beat_num
- beat_num  out  NUM_SONGS*BEAT_W  per-song beat index, addresses the tone ROMs
- active  out  NUM_SONGS  song playing
- done  out  NUM_SONGS  one-cycle pulse at song end or loop wrap
- sel  out  4  index of the selected song (valid when busy)
- busy  out  1  |active
- note_div_l, note_div_r  out  NDIV_W  divisors to `note_gen`

## Operation
- Per slot i: tempo counter tc[i] and beat counter beat_num[i]. When active, tc counts 0..tempo_div-1. A tick occurs at tempo_div-1, and tc then returns to 0. tempo_div==0 is treated as 1 (tick every cycle).
- On tick: if beat_num==song_len-1, the song ends; otherwise beat_num+1.
- Song end with loop_en[i]=1: beat_num<=0, active stays 1, done[i] pulses.
- Song end with loop_en[i]=0: beat_num<=0, active<=0, done[i] pulses.
- trigger[i]=1 with song_len[i]!=0: beat_num<=0, tc<=0, active<=1. Holding trigger holds the song at beat 0. Multiple triggers in one cycle are all honoured.
- trigger[i] with song_len[i]==0: ignored.
- Precedence per slot: stop > trigger > end/tick. A trigger coincident with song end restarts the song and suppresses done.
- stop: all active<=0, all beat_num<=0, all tc<=0, no done pulses.
- Selection: sel = lowest index with active=1. sel is combinational from registered active.
- Divider FSM, states IDLE and CALC, with two restoring dividers (L and R) running in parallel.
  - IDLE: if busy and (tone_l[sel],tone_r[sel]) differs from the latched pair, latch the pair, go to CALC, count=0.
  - CALC: one quotient bit per cycle for FREQ_W cycles. Then write note_div_l/r, saturated to 2^NDIV_W-1, and return to IDLE.
  - Latched tone==0 (rest) yields divisor 1, with no divide-by-zero.
  - Tone change during CALC: the current calculation completes, then IDLE re-evaluates.
- busy=0: note_div_l/r forced to 1 (silence) in the next cycle. The latched pair clears to 0, and any CALC in progress is aborted to IDLE.

## Timing
- Reset (rst=0, asynchronous): active=0, beat_num=0, tc=0, done=0, FSM=IDLE, latched tones=0, note_div_l=note_div_r=1.
- trigger sampled at cycle t: active=1 and beat_num=0 visible at t+1. First tick occurs tempo_div cycles after trigger release.
- done is registered, high for exactly the one cycle after the end tick.
- Divisor latency: tone change on the selected song to note_div update takes FREQ_W+2 cycles (34 at default). The previous divisor holds meanwhile.
- Tone ROMs are combinational from beat_num, and tones are sampled the cycle after a beat change.
- Minimum supported tempo_div is FREQ_W+2 for a divisor update every beat. Shorter tempos are legal, but some beats are skipped in note_div.

## Test plan
- Reset then idle: note_div_l/r=1, busy=0, all beat_num=0. Assert rst mid-song: all outputs return to reset values immediately.
- Song 2 with tempo_div=4, song_len=3, loop_en=0, one-cycle trigger: beat_num[2] steps 0,1,2 every 4 cycles. Then done[2] pulses once, active[2]=0, beat_num[2]=0.
- Same stimulus with loop_en=1: beat_num wraps 2→0, done pulses each wrap, active stays 1 for 3 loops.
- Songs 1 and 5 both active: sel=1. Stop only song 1 by letting it end: sel=5 the next cycle, and the divider recomputes.
- tone_l=440, tone_r=0 on the selected song: after 34 cycles note_div_l=113636 and note_div_r=1. Tone 1 saturates to 2^22-1.
- Trigger coincident with end tick: song restarts at 0 with no done pulse. stop together with trigger: all songs inactive.

Source files
------------

// File: rtl/music_sequencer_if.sv
// music_sequencer_if
//   Bundles the song-control, tone ROM and note divisor signals of the beat sequencer.
//   master : game-control / tone ROM side (drives triggers, song setup and tones)
//   slave  : music_sequencer side (drives beat indices, status and note divisors)
//   Per-song vectors are flattened; slot i sits at [i*W +: W].
interface music_sequencer_if #(
  parameter int NUM_SONGS = 9,
  parameter int BEAT_W    = 12,
  parameter int TEMPO_W   = 24,
  parameter int FREQ_W    = 32,
  parameter int NDIV_W    = 22
);
  logic [NUM_SONGS-1:0]         trigger;
  logic                         stop;
  logic [NUM_SONGS-1:0]         loop_en;
  logic [NUM_SONGS*TEMPO_W-1:0] tempo_div;
  logic [NUM_SONGS*BEAT_W-1:0]  song_len;
  logic [NUM_SONGS*FREQ_W-1:0]  tone_l;
  logic [NUM_SONGS*FREQ_W-1:0]  tone_r;
  logic [NUM_SONGS*BEAT_W-1:0]  beat_num;
  logic [NUM_SONGS-1:0]         active;
  logic [NUM_SONGS-1:0]         done;
  logic [3:0]                   sel;
  logic                         busy;
  logic [NDIV_W-1:0]            note_div_l;
  logic [NDIV_W-1:0]            note_div_r;

  modport master (
    output trigger, stop, loop_en, tempo_div, song_len, tone_l, tone_r,
    input  beat_num, active, done, sel, busy, note_div_l, note_div_r
  );

  modport slave (
    input  trigger, stop, loop_en, tempo_div, song_len, tone_l, tone_r,
    output beat_num, active, done, sel, busy, note_div_l, note_div_r
  );
endinterface

// File: rtl/music_sequencer.sv
// music_sequencer
//   Multi-song beat sequencer. Each slot has its own tempo counter, beat counter,
//   length and loop mode. The lowest-index playing song is selected, its tone ROM
//   outputs are turned into note divisors (DIV_NUM / tone) by two restoring
//   dividers running in parallel, and the result feeds note_gen.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : music_sequencer_if.slave
//          in : trigger, stop, loop_en, tempo_div, song_len, tone_l, tone_r
//          out: beat_num, active, done, sel, busy, note_div_l, note_div_r
module music_sequencer #(
  parameter int     NUM_SONGS = 9,
  parameter int     BEAT_W    = 12,
  parameter int     TEMPO_W   = 24,
  parameter int     FREQ_W    = 32,
  parameter int     NDIV_W    = 22,
  parameter longint DIV_NUM   = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  music_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(FREQ_W + 1);
  localparam logic [FREQ_W-1:0] DIVIDEND  = FREQ_W'(DIV_NUM);
  localparam logic [FREQ_W-1:0] SAT_LIMIT = FREQ_W'((64'd1 << NDIV_W) - 64'd1);

  // ---------------------------------------------------------------------------
  // Per-slot song state
  // ---------------------------------------------------------------------------
  logic [TEMPO_W-1:0]   tc_q   [NUM_SONGS];
  logic [BEAT_W-1:0]    beat_q [NUM_SONGS];
  logic [NUM_SONGS-1:0] active_q;
  logic [NUM_SONGS-1:0] done_q;

  logic [NUM_SONGS-1:0] tick;
  logic [NUM_SONGS-1:0] at_end;
  logic [NUM_SONGS-1:0] start;

  // tempo_div of 0 or 1 both mean a tick on every active cycle.
  always_comb begin
    tick   = '0;
    at_end = '0;
    start  = '0;
    for (int i = 0; i < NUM_SONGS; i++) begin
      tick[i] = active_q[i] &&
                ((bus.tempo_div[i*TEMPO_W +: TEMPO_W] <= TEMPO_W'(1)) ||
                 (tc_q[i] == bus.tempo_div[i*TEMPO_W +: TEMPO_W] - TEMPO_W'(1)));
      at_end[i] = (beat_q[i] == bus.song_len[i*BEAT_W +: BEAT_W] - BEAT_W'(1));
      start[i]  = bus.trigger[i] && (bus.song_len[i*BEAT_W +: BEAT_W] != '0);
    end
  end

  // Per-slot precedence is stop, then trigger, then the tempo tick. A trigger
  // landing on the end tick restarts the song and so never raises done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SONGS; i++) begin
        tc_q[i]   <= '0;
        beat_q[i] <= '0;
      end
      active_q <= '0;
      done_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_SONGS; i++) begin
        done_q[i] <= 1'b0;
        if (bus.stop) begin
          active_q[i] <= 1'b0;
          beat_q[i]   <= '0;
          tc_q[i]     <= '0;
        end else if (start[i]) begin
          active_q[i] <= 1'b1;
          beat_q[i]   <= '0;
          tc_q[i]     <= '0;
        end else if (active_q[i]) begin
          if (tick[i]) begin
            tc_q[i] <= '0;
            if (at_end[i]) begin
              beat_q[i]   <= '0;
              done_q[i]   <= 1'b1;
              active_q[i] <= bus.loop_en[i];
            end else begin
              beat_q[i] <= beat_q[i] + BEAT_W'(1);
            end
          end else begin
            tc_q[i] <= tc_q[i] + TEMPO_W'(1);
          end
        end
      end
    end
  end

  logic [NUM_SONGS*BEAT_W-1:0] beat_flat;

  always_comb begin
    beat_flat = '0;
    for (int i = 0; i < NUM_SONGS; i++) begin
      beat_flat[i*BEAT_W +: BEAT_W] = beat_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Fixed-priority selection: lowest playing slot wins
  // ---------------------------------------------------------------------------
  logic [3:0]        sel_idx;
  logic              busy;
  logic [FREQ_W-1:0] tone_sel_l;
  logic [FREQ_W-1:0] tone_sel_r;

  always_comb begin
    sel_idx = '0;
    busy    = |active_q;
    for (int i = NUM_SONGS - 1; i >= 0; i--) begin
      if (active_q[i]) begin
        sel_idx = 4'(i);
      end
    end
  end

  assign tone_sel_l = bus.tone_l[int'(sel_idx)*FREQ_W +: FREQ_W];
  assign tone_sel_r = bus.tone_r[int'(sel_idx)*FREQ_W +: FREQ_W];

  // ---------------------------------------------------------------------------
  // Divider FSM: two restoring dividers sharing one dividend shift register
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE, CALC} div_state_t;

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FREQ_W-1:0] lat_l_q, lat_l_d;
  logic [FREQ_W-1:0] lat_r_q, lat_r_d;
  logic [FREQ_W-1:0] dvd_q, dvd_d;
  logic [FREQ_W-1:0] rem_l_q, rem_l_d;
  logic [FREQ_W-1:0] rem_r_q, rem_r_d;
  logic [FREQ_W-1:0] quot_l_q, quot_l_d;
  logic [FREQ_W-1:0] quot_r_q, quot_r_d;
  logic [NDIV_W-1:0] ndiv_l_q, ndiv_l_d;
  logic [NDIV_W-1:0] ndiv_r_q, ndiv_r_d;

  logic [FREQ_W:0]   trial_l, trial_r;
  logic              fits_l, fits_r;
  logic [FREQ_W:0]   diff_l, diff_r;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The remainder stays below the
  // divisor, so FREQ_W bits hold it between steps.
  assign trial_l = {rem_l_q, dvd_q[FREQ_W-1]};
  assign trial_r = {rem_r_q, dvd_q[FREQ_W-1]};
  assign fits_l  = (trial_l >= {1'b0, lat_l_q});
  assign fits_r  = (trial_r >= {1'b0, lat_r_q});
  assign diff_l  = trial_l - {1'b0, lat_l_q};
  assign diff_r  = trial_r - {1'b0, lat_r_q};

  // A rest (tone 0) plays as divisor 1; anything too large to fit the
  // note_gen counter clamps to its maximum.
  function automatic logic [NDIV_W-1:0] to_ndiv(input logic [FREQ_W-1:0] quot,
                                                 input logic [FREQ_W-1:0] tone);
    if (tone == '0) begin
      return NDIV_W'(1);
    end else if (quot > SAT_LIMIT) begin
      return '1;
    end else begin
      return NDIV_W'(quot);
    end
  endfunction

  // Losing busy wins over everything: silence, forget the latched pair and
  // abandon any division so the next song starts from a clean compare.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lat_l_d  = lat_l_q;
    lat_r_d  = lat_r_q;
    dvd_d    = dvd_q;
    rem_l_d  = rem_l_q;
    rem_r_d  = rem_r_q;
    quot_l_d = quot_l_q;
    quot_r_d = quot_r_q;
    ndiv_l_d = ndiv_l_q;
    ndiv_r_d = ndiv_r_q;
    if (!busy) begin
      state_d  = IDLE;
      count_d  = '0;
      lat_l_d  = '0;
      lat_r_d  = '0;
      ndiv_l_d = NDIV_W'(1);
      ndiv_r_d = NDIV_W'(1);
    end else begin
      case (state_q)
        IDLE: begin
          if ((tone_sel_l != lat_l_q) || (tone_sel_r != lat_r_q)) begin
            state_d  = CALC;
            count_d  = '0;
            lat_l_d  = tone_sel_l;
            lat_r_d  = tone_sel_r;
            dvd_d    = DIVIDEND;
            rem_l_d  = '0;
            rem_r_d  = '0;
            quot_l_d = '0;
            quot_r_d = '0;
          end
        end
        CALC: begin
          // FREQ_W quotient steps, then one extra cycle to publish the result.
          if (count_q == CNT_W'(FREQ_W)) begin
            state_d  = IDLE;
            ndiv_l_d = to_ndiv(quot_l_q, lat_l_q);
            ndiv_r_d = to_ndiv(quot_r_q, lat_r_q);
          end else begin
            count_d  = count_q + CNT_W'(1);
            dvd_d    = dvd_q << 1;
            rem_l_d  = fits_l ? diff_l[FREQ_W-1:0] : trial_l[FREQ_W-1:0];
            rem_r_d  = fits_r ? diff_r[FREQ_W-1:0] : trial_r[FREQ_W-1:0];
            quot_l_d = {quot_l_q[FREQ_W-2:0], fits_l};
            quot_r_d = {quot_r_q[FREQ_W-2:0], fits_r};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      lat_l_q  <= '0;
      lat_r_q  <= '0;
      dvd_q    <= '0;
      rem_l_q  <= '0;
      rem_r_q  <= '0;
      quot_l_q <= '0;
      quot_r_q <= '0;
      ndiv_l_q <= NDIV_W'(1);
      ndiv_r_q <= NDIV_W'(1);
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      lat_l_q  <= lat_l_d;
      lat_r_q  <= lat_r_d;
      dvd_q    <= dvd_d;
      rem_l_q  <= rem_l_d;
      rem_r_q  <= rem_r_d;
      quot_l_q <= quot_l_d;
      quot_r_q <= quot_r_d;
      ndiv_l_q <= ndiv_l_d;
      ndiv_r_q <= ndiv_r_d;
    end
  end

  assign bus.beat_num   = beat_flat;
  assign bus.active     = active_q;
  assign bus.done       = done_q;
  assign bus.sel        = sel_idx;
  assign bus.busy       = busy;
  assign bus.note_div_l = ndiv_l_q;
  assign bus.note_div_r = ndiv_r_q;

endmodule
